sdram_arbiter: RTL and testbench

Two-port arbiter sharing the single `sdram` controller request interface between two clients, for example a video scanout reader and a CPU/test sequencer. It multiplexes read and write requests onto the controller's `rd_*`/`wr_*` ports using round-robin grants with a bounded run length. It keeps an in-order tag FIFO so that each returned read word is steered to the client that issued the read. It sits directly between the clients and `sdram`; the `sdram` controller itself is unchanged.

---
 rtl/sdram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// Two-client round-robin arbiter in front of the sdram controller request port.
// A tag FIFO of {port, len} steers returned read beats back to the issuing client.
module sdram_arbiter #(
    parameter int AW        = 20,
    parameter int MAX_RUN   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_rd_req,
    input  logic [AW-1:0] p0_rd_addr,
    input  logic [3:0]    p0_rd_len,
    output logic          p0_rd_ack,
    output logic          p0_rd_rdy,
    input  logic          p0_wr_req,
    input  logic [AW-1:0] p0_wr_addr,
    input  logic [15:0]   p0_wr_data,
    output logic          p0_wr_ack,
    input  logic          p1_rd_req,
    input  logic [AW-1:0] p1_rd_addr,
    input  logic [3:0]    p1_rd_len,
    output logic          p1_rd_ack,
    output logic          p1_rd_rdy,
    input  logic          p1_wr_req,
    input  logic [AW-1:0] p1_wr_addr,
    input  logic [15:0]   p1_wr_data,
    output logic          p1_wr_ack,
    output logic [15:0]   rd_data,
    output logic          m_rd_req,
    output logic [AW-1:0] m_rd_addr,
    output logic [3:0]    m_rd_len,
    input  logic          m_rd_ack,
    input  logic [15:0]   m_rd_data,
    input  logic          m_rd_rdy,
    output logic          m_wr_req,
    output logic [AW-1:0] m_wr_addr,
    output logic [15:0]   m_wr_data,
    input  logic          m_wr_ack
);
    // state | meaning
    // IDLE  | no grant; pick next port/op this cycle
    // GRANT | granted port/op drives the master side
    typedef enum logic {IDLE, GRANT} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0] RUN_LAST = 4'(MAX_RUN - 1);

    logic [1:0] sync_q, sync_d;
    logic       rst_n;

    assign sync_d = {sync_q[0], 1'b1};
    assign rst_n  = sync_q[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= sync_d;
    end

    state_t        state_q, state_d;
    op_t           gnt_op_q, gnt_op_d;
    logic          gnt_port_q, gnt_port_d;
    logic          rr_last_q, rr_last_d;
    logic [3:0]    run_q, run_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic [3:0]    beat_q, beat_d;
    logic          tag_err_q, tag_err_d;
    logic [4:0]    tag_mem_q [TAG_DEPTH];

    logic want0, want1, elig0, elig1, pick, in_gnt;
    logic sel_rd_req, sel_wr_req, sel_req, other_want;
    logic rd_ack_g, wr_ack_g, ack_g;
    logic empty, rdy_ok, push, pop, head_port;
    logic [3:0] head_len;

    assign want0      = p0_rd_req | p0_wr_req;
    assign want1      = p1_rd_req | p1_wr_req;
    // A read-only port is not eligible while the tag FIFO is full.
    assign elig0      = p0_wr_req | (p0_rd_req & ~full_q);
    assign elig1      = p1_wr_req | (p1_rd_req & ~full_q);
    assign pick       = (elig0 & elig1) ? ~rr_last_q : elig1;
    assign in_gnt     = (state_q == GRANT);
    assign sel_rd_req = gnt_port_q ? p1_rd_req : p0_rd_req;
    assign sel_wr_req = gnt_port_q ? p1_wr_req : p0_wr_req;
    assign sel_req    = (gnt_op_q == OP_WR) ? sel_wr_req : sel_rd_req;
    assign other_want = gnt_port_q ? want0 : want1;

    assign rd_ack_g  = in_gnt & (gnt_op_q == OP_RD) & m_rd_ack;
    assign wr_ack_g  = in_gnt & (gnt_op_q == OP_WR) & m_wr_ack;
    assign ack_g     = rd_ack_g | wr_ack_g;
    assign p0_rd_ack = rd_ack_g & ~gnt_port_q;
    assign p1_rd_ack = rd_ack_g &  gnt_port_q;
    assign p0_wr_ack = wr_ack_g & ~gnt_port_q;
    assign p1_wr_ack = wr_ack_g &  gnt_port_q;

    always_comb begin
        m_rd_req  = 1'b0;
        m_rd_addr = '0;
        m_rd_len  = '0;
        m_wr_req  = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
        if (in_gnt && gnt_op_q == OP_RD) begin
            m_rd_req  = sel_rd_req & ~full_q;
            m_rd_addr = gnt_port_q ? p1_rd_addr : p0_rd_addr;
            m_rd_len  = gnt_port_q ? p1_rd_len  : p0_rd_len;
        end
        if (in_gnt && gnt_op_q == OP_WR) begin
            m_wr_req  = sel_wr_req;
            m_wr_addr = gnt_port_q ? p1_wr_addr : p0_wr_addr;
            m_wr_data = gnt_port_q ? p1_wr_data : p0_wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_port_d = gnt_port_q;
        gnt_op_d   = gnt_op_q;
        rr_last_d  = rr_last_q;
        run_d      = run_q;
        case (state_q)
            IDLE: begin
                if (elig0 | elig1) begin
                    state_d    = GRANT;
                    gnt_port_d = pick;
                    rr_last_d  = pick;
                    run_d      = 4'd0;
                    gnt_op_d   = (pick ? p1_wr_req : p0_wr_req) ? OP_WR : OP_RD;
                end
            end
            GRANT: begin
                if (ack_g) begin
                    run_d = run_q + 4'd1;
                    if (other_want || run_q == RUN_LAST) state_d = IDLE;
                end else if (!sel_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign empty     = (count_q == '0);
    assign head_port = tag_mem_q[rd_ptr_q][4];
    assign head_len  = tag_mem_q[rd_ptr_q][3:0];
    assign rdy_ok    = m_rd_rdy & ~empty;
    assign pop       = rdy_ok & (beat_q == head_len);
    assign push      = rd_ack_g & (~full_q | pop);
    assign p0_rd_rdy = rdy_ok & ~head_port;
    assign p1_rd_rdy = rdy_ok &  head_port;
    assign rd_data   = rst_n ? m_rd_data : 16'h0000;

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d    = (count_d == CW'(TAG_DEPTH));
        beat_d    = beat_q;
        if (rdy_ok) beat_d = pop ? 4'd0 : beat_q + 4'd1;
        tag_err_d = tag_err_q | (m_rd_rdy & empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_op_q   <= OP_RD;
            gnt_port_q <= 1'b0;
            rr_last_q  <= 1'b1;
            run_q      <= 4'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            beat_q     <= 4'd0;
            tag_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_op_q   <= gnt_op_d;
            gnt_port_q <= gnt_port_d;
            rr_last_q  <= rr_last_d;
            run_q      <= run_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            beat_q     <= beat_d;
            tag_err_q  <= tag_err_d;
        end
    end

    // Entries are only read while count_q is non-zero, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) tag_mem_q[wr_ptr_q] <= {gnt_port_q, m_rd_len};
    end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural sdram model, ack/rdy scoreboards,
// a table of single-client transactions and sequences for arbitration corners.
module tb_sdram_arbiter;
    localparam int AW = 20;

    logic          clk;
    logic          reset_n;
    logic          p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req;
    logic [AW-1:0] p0_rd_addr, p0_wr_addr, p1_rd_addr, p1_wr_addr;
    logic [3:0]    p0_rd_len, p1_rd_len;
    logic [15:0]   p0_wr_data, p1_wr_data;
    logic          p0_rd_ack, p0_rd_rdy, p0_wr_ack, p1_rd_ack, p1_rd_rdy, p1_wr_ack;
    logic [15:0]   rd_data;
    logic          m_rd_req, m_rd_ack, m_rd_rdy, m_wr_req, m_wr_ack;
    logic [AW-1:0] m_rd_addr, m_wr_addr;
    logic [3:0]    m_rd_len;
    logic [15:0]   m_rd_data, m_wr_data;

    sdram_arbiter #(.AW(AW), .MAX_RUN(4), .TAG_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_rd_req(p0_rd_req), .p0_rd_addr(p0_rd_addr), .p0_rd_len(p0_rd_len),
        .p0_rd_ack(p0_rd_ack), .p0_rd_rdy(p0_rd_rdy),
        .p0_wr_req(p0_wr_req), .p0_wr_addr(p0_wr_addr), .p0_wr_data(p0_wr_data), .p0_wr_ack(p0_wr_ack),
        .p1_rd_req(p1_rd_req), .p1_rd_addr(p1_rd_addr), .p1_rd_len(p1_rd_len),
        .p1_rd_ack(p1_rd_ack), .p1_rd_rdy(p1_rd_rdy),
        .p1_wr_req(p1_wr_req), .p1_wr_addr(p1_wr_addr), .p1_wr_data(p1_wr_data), .p1_wr_ack(p1_wr_ack),
        .rd_data(rd_data),
        .m_rd_req(m_rd_req), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len), .m_rd_ack(m_rd_ack),
        .m_rd_data(m_rd_data), .m_rd_rdy(m_rd_rdy),
        .m_wr_req(m_wr_req), .m_wr_addr(m_wr_addr), .m_wr_data(m_wr_data), .m_wr_ack(m_wr_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // sdram model: ack one cycle after a request, beats returned in order
    logic       stall_rdy;
    logic       inject;
    int         pend_q[$];
    int         beat_m;
    logic [15:0] data_ctr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_rd_ack  <= 1'b0;
            m_wr_ack  <= 1'b0;
            m_rd_rdy  <= 1'b0;
            m_rd_data <= 16'h0000;
            beat_m    <= 0;
            data_ctr  <= 16'h0100;
            pend_q.delete();
        end else begin
            m_rd_rdy  <= 1'b0;
            m_rd_data <= 16'h0000;
            if (inject) begin
                m_rd_rdy  <= 1'b1;
                m_rd_data <= 16'hDEAD;
            end else if (!stall_rdy && pend_q.size() > 0) begin
                m_rd_rdy  <= 1'b1;
                m_rd_data <= data_ctr;
                data_ctr  <= data_ctr + 16'h1;
                if (beat_m == pend_q[0]) begin
                    void'(pend_q.pop_front());
                    beat_m <= 0;
                end else begin
                    beat_m <= beat_m + 1;
                end
            end
            if (m_rd_req && !m_rd_ack) pend_q.push_back(int'(m_rd_len));
            m_rd_ack <= m_rd_req && !m_rd_ack;
            m_wr_ack <= m_wr_req && !m_wr_ack;
        end
    end

    // Scoreboards: ack code = port*2 + is_wr, rdy entry = port
    int   ack_q[$];
    int   rdy_q[$];
    int   ack_cnt[4];
    int   grant_cnt;
    logic prev_rd_req;

    initial begin
        for (int k = 0; k < 4; k++) ack_cnt[k] = 0;
        grant_cnt   = 0;
        prev_rd_req = 1'b0;
    end

    always @(negedge clk) begin
        logic [3:0] acks;
        int code;
        acks = {p1_wr_ack, p1_rd_ack, p0_wr_ack, p0_rd_ack};
        if (reset_n) begin
            if (m_rd_req && !prev_rd_req) grant_cnt++;
            for (int k = 0; k < 4; k++) begin
                if (acks[k]) begin
                    ack_cnt[k]++;
                    if (ack_q.size() == 0) check("ack_unexpected", k, 99);
                    else begin
                        code = ack_q.pop_front();
                        check("ack_order", k, code);
                    end
                end
            end
            if (p0_rd_rdy && p1_rd_rdy) check("rdy_both_ports", 2, 1);
            else if (p0_rd_rdy || p1_rd_rdy) begin
                check("rdy_data_broadcast", rd_data, m_rd_data);
                if (rdy_q.size() == 0) check("rdy_unexpected", p1_rd_rdy, 99);
                else begin
                    code = rdy_q.pop_front();
                    check("rdy_port", p1_rd_rdy, code);
                end
            end
        end
        prev_rd_req = m_rd_req;
    end

    function automatic logic all_out();
        return p0_rd_ack | p0_rd_rdy | p0_wr_ack | p1_rd_ack | p1_rd_rdy | p1_wr_ack |
               (|rd_data) | m_rd_req | (|m_rd_addr) | (|m_rd_len) |
               m_wr_req | (|m_wr_addr) | (|m_wr_data);
    endfunction

    function automatic logic ack_of(input int port, input int is_wr);
        if (port == 0) return (is_wr != 0) ? p0_wr_ack : p0_rd_ack;
        return (is_wr != 0) ? p1_wr_ack : p1_rd_ack;
    endfunction

    task automatic set_fields(input int port, input int is_wr, input logic [AW-1:0] addr,
                              input logic [3:0] len, input logic [15:0] data);
        if (port == 0 && is_wr == 0) begin p0_rd_addr = addr; p0_rd_len = len; end
        else if (port == 0)          begin p0_wr_addr = addr; p0_wr_data = data; end
        else if (is_wr == 0)         begin p1_rd_addr = addr; p1_rd_len = len; end
        else                         begin p1_wr_addr = addr; p1_wr_data = data; end
    endtask

    task automatic set_req(input int port, input int is_wr, input logic v);
        if (port == 0 && is_wr == 0) p0_rd_req = v;
        else if (port == 0)          p0_wr_req = v;
        else if (is_wr == 0)         p1_rd_req = v;
        else                         p1_wr_req = v;
    endtask

    // Holds its request for n_ops acks, moving to the next address on each ack.
    task automatic client(input int port, input int is_wr, input int n_ops,
                          input logic [AW-1:0] base, input logic [3:0] len);
        int got = 0;
        int budget = 0;
        @(negedge clk);
        set_fields(port, is_wr, base, len, 16'hA000);
        set_req(port, is_wr, 1'b1);
        while (got < n_ops && budget <= 300) begin
            @(negedge clk);
            budget++;
            if (ack_of(port, is_wr)) begin
                got++;
                budget = 0;
                if (got == n_ops) set_req(port, is_wr, 1'b0);
                else set_fields(port, is_wr, base + AW'(got), len, 16'hA000 + 16'(got));
            end
        end
        if (got < n_ops) begin
            set_req(port, is_wr, 1'b0);
            check("client_ack_timeout", got, n_ops);
        end
    endtask

    task automatic drain(input string name);
        int b = 0;
        while ((ack_q.size() != 0 || rdy_q.size() != 0) && b < 400) begin
            @(negedge clk);
            b++;
        end
        check(name, ack_q.size() + rdy_q.size(), 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_outputs_zero", all_out(), 0);
        repeat (2) @(negedge clk);
        check("rst_outputs_zero_hold", all_out(), 0);
        ack_q.delete();
        rdy_q.delete();
        p0_rd_req = 1'b0; p0_wr_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b0;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int            port;
        int            is_wr;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [15:0]   data;
        int            exp_code;
        int            exp_beats;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   b;
        int   base0;
        int   hi;
        int   g0;

        vecs[0] = '{0, 0, 20'h00010, 4'd3,  16'h0000, 0, 4};
        vecs[1] = '{1, 1, 20'h12345, 4'd0,  16'hBEEF, 3, 0};
        vecs[2] = '{1, 0, 20'hFFFFF, 4'd0,  16'h0000, 2, 1};
        vecs[3] = '{0, 1, 20'h00000, 4'd0,  16'h0001, 1, 0};
        vecs[4] = '{0, 0, 20'h80001, 4'd15, 16'h0000, 0, 16};
        vecs[5] = '{1, 0, 20'h0ABCD, 4'd2,  16'h0000, 2, 3};

        reset_n = 1'b0;
        stall_rdy = 1'b0;
        inject = 1'b0;
        p0_rd_addr = '0; p0_rd_len = '0; p0_wr_addr = '0; p0_wr_data = '0;
        p1_rd_addr = '0; p1_rd_len = '0; p1_wr_addr = '0; p1_wr_data = '0;
        p0_rd_req = 1'b1; p0_wr_req = 1'b0; p1_rd_req = 1'b0; p1_wr_req = 1'b1;
        @(negedge clk);
        check("rst_rr_last", dut.rr_last_q, 1);
        do_reset();

        // Single-client transactions
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            ack_q.push_back(v.exp_code);
            for (int k = 0; k < v.exp_beats; k++) rdy_q.push_back(v.port);
            @(negedge clk);
            set_fields(v.port, v.is_wr, v.addr, v.len, v.data);
            set_req(v.port, v.is_wr, 1'b1);
            b = 0;
            while (!((v.is_wr != 0) ? m_wr_req : m_rd_req) && b < 50) begin @(negedge clk); b++; end
            if (v.is_wr != 0) begin
                check("vec_m_wr_addr", m_wr_addr, v.addr);
                check("vec_m_wr_data", m_wr_data, v.data);
            end else begin
                check("vec_m_rd_addr", m_rd_addr, v.addr);
                check("vec_m_rd_len", m_rd_len, v.len);
            end
            b = 0;
            while (!ack_of(v.port, v.is_wr) && b < 50) begin @(negedge clk); b++; end
            check("vec_ack_seen", ack_of(v.port, v.is_wr), 1);
            set_req(v.port, v.is_wr, 1'b0);
            drain("vec_drain");
        end

        // Tie after reset: port 0 first, beats steered in issue order
        do_reset();
        ack_q.push_back(0); ack_q.push_back(2);
        for (int k = 0; k < 3; k++) rdy_q.push_back(0);
        for (int k = 0; k < 2; k++) rdy_q.push_back(1);
        fork
            client(0, 0, 1, 20'h00100, 4'd2);
            client(1, 0, 1, 20'h00200, 4'd1);
        join
        drain("tie_drain");

        // Contention: port 0 reads vs port 1 writes strictly alternate
        do_reset();
        for (int k = 0; k < 10; k++) begin ack_q.push_back(0); ack_q.push_back(3); rdy_q.push_back(0); end
        fork
            client(0, 0, 10, 20'h01000, 4'd0);
            client(1, 1, 10, 20'h02000, 4'd0);
        join
        drain("alt_drain");

        // Lone streamer: 10 acks in grants of 4, 4, 2
        g0 = grant_cnt;
        for (int k = 0; k < 10; k++) begin ack_q.push_back(0); rdy_q.push_back(0); end
        client(0, 0, 10, 20'h03000, 4'd0);
        drain("run_drain");
        check("run_grant_count", grant_cnt - g0, 3);

        // Port 1 write and read together: write first
        for (int k = 0; k < 2; k++) rdy_q.push_back(1);
        ack_q.push_back(3); ack_q.push_back(2);
        fork
            client(1, 1, 1, 20'h04000, 4'd0);
            client(1, 0, 1, 20'h05000, 4'd1);
        join
        drain("wr_first_drain");

        // Full tag FIFO with stalled data return
        stall_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin ack_q.push_back(0); rdy_q.push_back(0); end
        base0 = ack_cnt[0];
        hi = 0;
        fork
            client(0, 0, 6, 20'h06000, 4'd0);
            begin
                repeat (40) begin
                    @(negedge clk);
                    if (ack_cnt[0] - base0 >= 4 && !p0_rd_ack && m_rd_req) hi++;
                end
                check("stall_ack_count", ack_cnt[0] - base0, 4);
                check("stall_req_gated", hi, 0);
                stall_rdy = 1'b0;
            end
        join
        drain("stall_drain");
        check("stall_total_acks", ack_cnt[0] - base0, 6);

        // Data beat with nothing outstanding
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check("orphan_rd_data", rd_data, 16'hDEAD);
        check("orphan_no_rdy", p0_rd_rdy | p1_rd_rdy, 0);
        @(negedge clk);
        check("orphan_tag_err", dut.tag_err_q, 1);

        // Reset in the middle of a burst, requests held through reset
        ack_q.push_back(0);
        for (int k = 0; k < 8; k++) rdy_q.push_back(0);
        client(0, 0, 1, 20'h00300, 4'd7);
        b = 0;
        while (rdy_q.size() > 5 && b < 100) begin @(negedge clk); b++; end
        check("midburst_beats_before_reset", rdy_q.size(), 5);
        p0_rd_req = 1'b1; p1_rd_req = 1'b1; p1_wr_req = 1'b1;
        do_reset();
        check("reset_clears_tag_err", dut.tag_err_q, 0);
        ack_q.push_back(0);
        for (int k = 0; k < 2; k++) rdy_q.push_back(0);
        client(0, 0, 1, 20'h00400, 4'd1);
        drain("post_reset_drain");
        check("final_tag_err", dut.tag_err_q, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
